config_accumulator: RTL
=======================

Name: config_accumulator

Overview:
- Downstream consumer of the configurable 8-bit multiplier's 16-bit product.
- Accumulates a stream of products over a run-time vector length, as one, two or four independent signed lanes chosen by halvedPrecision.
- Returns the packed sums through a valid/ready output register.
- Forms the accumulate half of a precision-scalable MAC.

Parameters:
- ACC_WIDTH, 32, total accumulator width; must be divisible by 4 and at least 16.
- LEN_WIDTH, 8, width of the vector-length input.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- product_i  in  16  packed multiplier product: 16 (mode 00), 8_8 (mode 10), 4_4_4_4 (mode 01).
- halvedPrecision_i  in  2  precision mode, same encoding as the multiplier; 11 is treated as 01.
- len_i  in  LEN_WIDTH  number of products per run; 0 is treated as 1.
- in_valid_i  in  1  product_i is valid.
- in_ready_o  out  1  block accepts product_i.
- clear_i  in  1  synchronous abort: returns to IDLE and zeroes the accumulators.
- acc_o  out  ACC_WIDTH  packed lane sums; lane k occupies bits [(k+1)*L-1 : k*L].
- out_valid_o  out  1  acc_o holds a finished result.
- out_ready_i  in  1  downstream accepts acc_o.
- busy_o  out  1  a run is in progress (state ACCUM).

Behaviour:
- Reset (asynchronous) values: state = IDLE, accumulators = 0, count = 0, acc_o = 0, out_valid_o = 0, in_ready_o = 1, busy_o = 0.
- Lane layout per mode:
  - mode 00: 1 lane, L = ACC_WIDTH, source product_i[15:0].
  - mode 10: 2 lanes, L = ACC_WIDTH/2, sources product_i[7:0] and [15:8].
  - mode 01: 4 lanes, L = ACC_WIDTH/4, sources [3:0], [7:4], [11:8], [15:12].
- Lane arithmetic:
  - Each source slice is sign-extended to L bits and added to its lane.
  - Two's-complement wrap-around; no saturation.
  - Carries never cross lane boundaries.
- Fire: input fire = in_valid_i & in_ready_o; output fire = out_valid_o & out_ready_i.
- FSM:
  - IDLE: in_ready_o = 1. On input fire:
    - latch mode and len (len 0 becomes 1);
    - load accumulators with the first product (no add to stale data); count = 1;
    - if len_eff == 1, go to DONE, else go to ACCUM.
  - ACCUM: in_ready_o = 1, busy_o = 1. On input fire: add the product to the lanes; count++. On the fire where count+1 == len_eff, go to DONE.
  - DONE: out_valid_o = 1, in_ready_o = 0, acc_o stable. On output fire, go to IDLE with out_valid_o = 0 on the next cycle.
- Latency and bubble: acc_o and out_valid_o rise the cycle after the last input fire. There is exactly one bubble cycle between runs.
- Mode and length lock: halvedPrecision_i and len_i are sampled only on the first fire of a run. Changes mid-run are ignored.
- Unused lanes: acc_o bits outside active lanes do not exist; every mode covers the full ACC_WIDTH.
- Clear:
  - clear_i has priority over all other events in every state.
  - It drops out_valid_o without an output handshake and discards any simultaneous input beat.
- Counter: count never exceeds len_eff. A len of 2^LEN_WIDTH-1 completes normally without wrap.
- Mid-operation reset: rst_i mid-run returns everything to reset values immediately; no partial result is emitted.

Decomposition:
- Shared package config_mult_pkg:
  - precision enum: PREC_FULL = 2'b00, PREC_HALF = 2'b10, PREC_QUARTER = 2'b01;
  - FSM state enum: IDLE, ACCUM, DONE;
  - lane-count function mapping mode to 1/2/4.
- Sub-module lane_split_adder (combinational):
  - adds a sign-extended packed operand to the accumulator register;
  - carry chain is broken at L/2 and L/4 boundaries according to mode;
  - mirrors the multiplier's split structure.
- Top level holds the FSM, counter, registers and handshake.

Test Plan:
- Mode 00, len 3, products 16'hFFFF, 16'h7FFF, 16'h0002 -> one output, acc_o = 32'h0000_8000, out_valid_o rises 1 cycle after the 3rd fire.
- Mode 10, len 2, products 16'h7F80 then 16'h0101 -> lane0 = 0xFF80 + 1 = 16'hFF81, lane1 = 0x7F + 1 = 16'h0080; acc_o = 32'h0080_FF81.
- Mode 01, len 4, product 16'h8F17 four times -> lanes (4-bit sources 7, 1, F, 8) summed ×4: acc_o = {8'hE0, 8'hFC, 8'h04, 8'h1C} = 32'hE0FC_041C.
- Wrap: mode 01, len 20, product 16'h0007 each beat -> lane0 = 140 mod 256 = 8'h8C, other lanes 0.
- Backpressure: out_ready_i held low 5 cycles in DONE -> out_valid_o and acc_o stable, in_ready_o = 0. Then out_ready_i = 1 -> IDLE next cycle, and the next run starts from fresh values (not summed with the old result).
- Corners:
  - len_i = 0 behaves as len 1;
  - clear_i asserted mid-ACCUM together with in_valid_i -> beat dropped, IDLE, acc 0;
  - rst_i mid-run -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/config_mult_pkg.sv
// Shared types and helpers for the precision-scalable multiplier / accumulator pair.
// Encodings match the multiplier's halvedPrecision field.
package config_mult_pkg;

  typedef enum logic [1:0] {
    PREC_FULL    = 2'b00,
    PREC_HALF    = 2'b10,
    PREC_QUARTER = 2'b01
  } precT;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } stateT;

  localparam int PRODUCT_W = 16;

  // The unused code 2'b11 behaves as quarter precision.
  function automatic precT normPrec(input logic [1:0] mode);
    case (mode)
      2'b00:   return PREC_FULL;
      2'b10:   return PREC_HALF;
      default: return PREC_QUARTER;
    endcase
  endfunction

  function automatic int laneCount(input precT mode);
    case (mode)
      PREC_FULL: return 1;
      PREC_HALF: return 2;
      default:   return 4;
    endcase
  endfunction

endpackage

// File: rtl/config_accumulator_if.sv
// Product-in / sum-out handshake bundle of the accumulator.
// master = upstream/downstream environment, slave = accumulator.
interface config_accumulator_if #(
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 8
);

  logic [15:0]          product_i;
  logic [1:0]           halvedPrecision_i;
  logic [LEN_WIDTH-1:0] len_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic                 clear_i;
  logic [ACC_WIDTH-1:0] acc_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 busy_o;

  modport master (
    output product_i, halvedPrecision_i, len_i, in_valid_i, clear_i, out_ready_i,
    input  in_ready_o, acc_o, out_valid_o, busy_o
  );

  modport slave (
    input  product_i, halvedPrecision_i, len_i, in_valid_i, clear_i, out_ready_i,
    output in_ready_o, acc_o, out_valid_o, busy_o
  );

endinterface

// File: rtl/lane_split_adder.sv
// Lane-partitioned adder: adds a sign-extended packed product to the accumulator,
// cutting the carry chain at half/quarter boundaries according to the precision mode.
module lane_split_adder
  import config_mult_pkg::*;
#(
  parameter int ACC_WIDTH = 32
) (
  input  precT                        mode,
  input  logic                        load,
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic [PRODUCT_W-1:0]        product,
  output logic signed [ACC_WIDTH-1:0] sum
);

  localparam int HW = ACC_WIDTH / 2;
  localparam int QW = ACC_WIDTH / 4;

  logic signed [ACC_WIDTH-1:0] opFull;
  logic signed [ACC_WIDTH-1:0] opHalf;
  logic signed [ACC_WIDTH-1:0] opQuarter;
  logic signed [ACC_WIDTH-1:0] operand;
  logic signed [ACC_WIDTH-1:0] base;
  logic [3:0]                  passCarry;
  logic                        carry;

  always_comb begin
    opFull = ACC_WIDTH'(signed'(product));
    for (int k = 0; k < 2; k++) begin
      opHalf[k*HW +: HW] = HW'(signed'(product[k*8 +: 8]));
    end
    for (int k = 0; k < 4; k++) begin
      opQuarter[k*QW +: QW] = QW'(signed'(product[k*4 +: 4]));
    end

    case (mode)
      PREC_FULL: operand = opFull;
      PREC_HALF: operand = opHalf;
      default:   operand = opQuarter;
    endcase

    // Quarter k receives the carry out of quarter k-1 only when both sit in one lane.
    passCarry[0] = 1'b0;
    passCarry[1] = (laneCount(mode) != 4);
    passCarry[2] = (laneCount(mode) == 1);
    passCarry[3] = (laneCount(mode) != 4);

    // The first beat of a run overwrites rather than adds to the previous result.
    base  = load ? '0 : acc;
    carry = 1'b0;
    sum   = '0;
    for (int k = 0; k < 4; k++) begin
      {carry, sum[k*QW +: QW]} = {1'b0, base[k*QW +: QW]}
                               + {1'b0, operand[k*QW +: QW]}
                               + {{QW{1'b0}}, carry & passCarry[k]};
    end
  end

endmodule

// File: rtl/config_accumulator.sv
// Accumulate half of the precision-scalable MAC: sums a run of packed products in
// 1/2/4 signed lanes and presents the packed result through a valid/ready register.
module config_accumulator
  import config_mult_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  config_accumulator_if.slave bus
);

  stateT                       state;
  precT                        modeReg;
  logic [LEN_WIDTH-1:0]        lenReg;
  logic [LEN_WIDTH-1:0]        count;
  logic signed [ACC_WIDTH-1:0] accReg;
  logic                        inReady;
  logic                        outValid;
  logic                        busy;

  precT                        modeIn;
  precT                        addMode;
  logic [LEN_WIDTH-1:0]        lenIn;
  logic                        firstBeat;
  logic                        inFire;
  logic                        outFire;
  logic                        lastBeat;
  logic signed [ACC_WIDTH-1:0] accNext;

  assign modeIn    = normPrec(bus.halvedPrecision_i);
  assign lenIn     = (bus.len_i == '0) ? LEN_WIDTH'(1) : bus.len_i;
  assign firstBeat = (state == IDLE);
  assign addMode   = firstBeat ? modeIn : modeReg;
  assign inFire    = bus.in_valid_i & inReady;
  assign outFire   = outValid & bus.out_ready_i;
  // One extra bit keeps the compare exact when the length is all ones.
  assign lastBeat  = (({1'b0, count} + (LEN_WIDTH+1)'(1)) == {1'b0, lenReg});

  lane_split_adder #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_adder (
    .mode    (addMode),
    .load    (firstBeat),
    .acc     (accReg),
    .product (bus.product_i),
    .sum     (accNext)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      modeReg  <= PREC_FULL;
      lenReg   <= LEN_WIDTH'(1);
      count    <= '0;
      accReg   <= '0;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      busy     <= 1'b0;
    end else if (bus.clear_i) begin
      state    <= IDLE;
      count    <= '0;
      accReg   <= '0;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inFire) begin
            modeReg <= modeIn;
            lenReg  <= lenIn;
            accReg  <= accNext;
            count   <= LEN_WIDTH'(1);
            if (lenIn == LEN_WIDTH'(1)) begin
              state    <= DONE;
              inReady  <= 1'b0;
              outValid <= 1'b1;
            end else begin
              state <= ACCUM;
              busy  <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (inFire) begin
            accReg <= accNext;
            count  <= count + LEN_WIDTH'(1);
            if (lastBeat) begin
              state    <= DONE;
              inReady  <= 1'b0;
              outValid <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end
        DONE: begin
          if (outFire) begin
            state    <= IDLE;
            count    <= '0;
            inReady  <= 1'b1;
            outValid <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          inReady  <= 1'b1;
          outValid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc_o       = accReg;
  assign bus.in_ready_o  = inReady;
  assign bus.out_valid_o = outValid;
  assign bus.busy_o      = busy;

endmodule
